// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Purpose: generates raster timing for a VGA display from the pixel clock.
// Timing starts only after the PLL has reported lock for a continuous
// settle window. While timing runs, it drives the syncs, data enable, the
// active-area pixel coordinates and an 8-bar colour test pattern.
//
// Ports:
//   clk          in   pixel clock (the only clock)
//   rst_n        in   synchronous active-low reset
//   pll_lock     in   PLL lock, asynchronous until locked; double-registered
//   hsync        out  horizontal sync, active-high
//   vsync        out  vertical sync, active-high
//   de           out  data enable, high in the active area
//   pix_x        out  active column (0 when de is low)
//   pix_y        out  active row (0 when de is low)
//   frame_start  out  one-clock pulse on the first active pixel of a frame
//   rgb          out  {R,G,B} test pattern (0 when de is low)
//
// All outputs are registered in one stage, so they are mutually aligned and
// lag the raster counters by one clock.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 48,
    parameter int H_SYNC      = 112,
    parameter int H_BP        = 248,
    parameter int V_ACTIVE    = 1024,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 38,
    parameter int LOCK_SETTLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_N  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_W_N  = HW'(BAR_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_N  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SET_LAST = SW'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic            lock_meta_q, lock_meta_d;
    logic            lock_sync_q, lock_sync_d;

    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [10:0]     pix_x_q, pix_x_d;
    logic [10:0]     pix_y_q, pix_y_d;
    logic            frame_start_q, frame_start_d;
    logic [23:0]     rgb_q, rgb_d;

    logic            active;
    logic [HW-1:0]   bar_idx;

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        lock_meta_d   = pll_lock;
        lock_sync_d   = lock_meta_q;
        hsync_d       = 1'b0;
        vsync_d       = 1'b0;
        de_d          = 1'b0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        frame_start_d = 1'b0;
        rgb_d         = '0;
        active        = 1'b0;
        bar_idx       = '0;

        unique case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                if (lock_sync_q) begin
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (!lock_sync_q) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SET_LAST) begin
                    state_d  = RUN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            RUN: begin
                if (!lock_sync_q) begin
                    state_d = WAIT_LOCK;
                end

                // Counters advance even on the exit edge; WAIT_LOCK forces
                // them back to 0 on the following clock, so a lost frame
                // never resumes mid-way.
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                    v_cnt_d = v_cnt_q;
                end

                active        = (h_cnt_q < H_ACT_N) && (v_cnt_q < V_ACT_N);
                bar_idx       = h_cnt_q / BAR_W_N;
                hsync_d       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
                vsync_d       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
                de_d          = active;
                frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
                if (active) begin
                    pix_x_d = 11'(h_cnt_q);
                    pix_y_d = 11'(v_cnt_q);
                    rgb_d   = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
                end
            end

            default: begin
                state_d  = WAIT_LOCK;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_LOCK;
            settle_q      <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            lock_meta_q   <= 1'b0;
            lock_sync_q   <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            lock_meta_q   <= lock_meta_d;
            lock_sync_q   <= lock_sync_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (24 x 10 clocks, 16 x 6
// active) so full frames fit in a short run. A raster model predicts every
// output from the time elapsed since timing started; directed sequences pin
// latencies, bar colours and sync placement with hand-computed literals.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int LS = 16;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 10

    logic        clk;
    logic        rst_n;
    logic        pll_lock;
    logic        hsync, vsync, de, frame_start;
    logic [10:0] pix_x, pix_y;
    logic [23:0] rgb;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LOCK_SETTLE(LS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .rgb(rgb)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    // ---------------- raster model ----------------
    // Expected outputs for a raster that has been running for 'age' clocks.
    function automatic logic [49:0] model_out(int age);
        int p, h, v, b;
        logic [2:0]  bb;
        logic        m_de, m_hs, m_vs, m_fs;
        logic [10:0] m_px, m_py;
        logic [23:0] m_rgb;
        p     = age % (HT * VT);
        h     = p % HT;
        v     = p / HT;
        m_de  = (h < HA) && (v < VA);
        m_hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
        m_vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
        m_fs  = (p == 0);
        b     = h / (HA / 8);
        bb    = 3'(b);
        m_px  = m_de ? 11'(h) : 11'd0;
        m_py  = m_de ? 11'(v) : 11'd0;
        m_rgb = m_de ? {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}} : 24'd0;
        return {m_hs, m_vs, m_de, m_fs, m_px, m_py, m_rgb};
    endfunction

    // Lock bookkeeping: the synchronized lock is pll_lock two clocks late;
    // timing runs once it has been seen high on LS+1 consecutive clocks
    // (one to leave WAIT_LOCK, LS in the settle window).
    int   m_consec = 0;
    int   m_age    = 0;
    bit   m_run    = 0;
    bit   m_s1     = 0;
    bit   m_s2     = 0;
    bit   mon_en   = 0;
    int   mon_prints = 0;

    always @(negedge clk) begin
        logic [49:0] exp_v, got_v;
        bit sync_b;
        exp_v = '0;
        if (rst_n && m_run) exp_v = model_out(m_age);
        if (!rst_n) mon_en = 1;
        if (mon_en) begin
            got_v = {hsync, vsync, de, frame_start, pix_x, pix_y, rgb};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (mon_prints < 10) begin
                    mon_prints++;
                    $display("FAIL raster_model t=%0t got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h",
                             $time, got_v[49], got_v[48], got_v[47], got_v[46],
                             got_v[45:35], got_v[34:24], got_v[23:0],
                             exp_v[49], exp_v[48], exp_v[47], exp_v[46],
                             exp_v[45:35], exp_v[34:24], exp_v[23:0]);
                end
            end
        end
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_consec = 0; m_run = 0; m_age = 0;
        end else begin
            sync_b   = m_s2;
            m_s2     = m_s1;
            m_s1     = pll_lock;
            m_consec = sync_b ? m_consec + 1 : 0;
            if (m_consec >= LS + 1) begin
                m_age = m_run ? m_age + 1 : 0;
                m_run = 1;
            end else begin
                m_run = 0;
            end
        end
    end

    // ---------------- driver / directed checks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_de"},    32'(de), 0);
        check({tag, "_hsync"}, 32'(hsync), 0);
        check({tag, "_vsync"}, 32'(vsync), 0);
        check({tag, "_fs"},    32'(frame_start), 0);
        check({tag, "_pix_x"}, 32'(pix_x), 0);
        check({tag, "_pix_y"}, 32'(pix_y), 0);
        check({tag, "_rgb"},   32'(rgb), 0);
    endtask

    // Steps until frame_start is seen; n = steps taken, 0 if never seen.
    task automatic wait_fs(input int max_steps, output int n);
        n = 0;
        for (int i = 1; i <= max_steps; i++) begin
            step();
            if (frame_start) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int de_cnt, hs_cnt, vs_cnt, vs_first, fs_extra;
        bit found;

        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (3) step();
        check_idle("reset");

        #1 rst_n = 1'b1;
        repeat (2) step();
        check_idle("wait_lock");

        // Startup: 2 sync + 1 + 16 settle clocks to RUN, frame_start next.
        #1 pll_lock = 1'b1;
        wait_fs(60, n);
        check("startup_latency", 32'(n), 20);
        check("fs_de",    32'(de), 1);
        check("fs_pix_x", 32'(pix_x), 0);
        check("fs_pix_y", 32'(pix_y), 0);
        check("fs_rgb",   32'(rgb), 0);

        // One full frame from the frame_start cycle.
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_first = -1; fs_extra = 0;
        for (int i = 1; i <= HT * VT; i++) begin
            step();
            if (de) de_cnt++;
            if (hsync) hs_cnt++;
            if (vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (frame_start && i < HT * VT) fs_extra++;
            if (i == 2)  check("bar1_rgb", 32'(rgb), 32'h0000FF);
            if (i == 5)  check("bar2_rgb", 32'(rgb), 32'h00FF00);
            if (i == 15) check("bar7_rgb", 32'(rgb), 32'hFFFFFF);
            if (i == 16) begin
                check("blank_de",  32'(de), 0);
                check("blank_rgb", 32'(rgb), 0);
            end
            if (i == 17) check("hsync_before", 32'(hsync), 0);
            if (i == 18) check("hsync_rise",   32'(hsync), 1);
            if (i == 21) check("hsync_fall",   32'(hsync), 0);
            if (i == 24) begin
                check("line1_pix_y", 32'(pix_y), 1);
                check("line1_pix_x", 32'(pix_x), 0);
            end
            if (i == HT * VT) check("frame_period_fs", 32'(frame_start), 1);
        end
        check("frame_de_clocks",    32'(de_cnt), 96);
        check("frame_hsync_clocks", 32'(hs_cnt), 30);
        check("frame_vsync_clocks", 32'(vs_cnt), 48);
        check("vsync_first_clock",  32'(vs_first), 168);
        check("no_extra_fs",        32'(fs_extra), 0);

        // Lock loss in the middle of the active area (row 3, column 5).
        found = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (de && pix_y == 11'd3 && pix_x == 11'd5) begin
                found = 1;
                break;
            end
        end
        check("reach_row3", 32'(found), 1);
        #1 pll_lock = 1'b0;
        repeat (3) step();
        check("loss_still_running", 32'(de), 1);
        step();
        check_idle("loss");
        repeat (2) step();
        #1 pll_lock = 1'b1;
        wait_fs(60, n);
        check("relock_latency", 32'(n), 20);
        check("relock_pix_x", 32'(pix_x), 0);
        check("relock_pix_y", 32'(pix_y), 0);
        step();
        check("relock_next_x", 32'(pix_x), 1);
        check("relock_next_y", 32'(pix_y), 0);

        // One-clock lock glitch during the settle window restarts settling.
        #1 pll_lock = 1'b0;
        repeat (6) step();
        check("pre_glitch_de", 32'(de), 0);
        #1 pll_lock = 1'b1;
        repeat (12) step();
        #1 pll_lock = 1'b0;
        step();
        #1 pll_lock = 1'b1;
        wait_fs(60, n);
        check("glitch_relock_latency", 32'(n), 20);

        // Reset mid-RUN with lock held high needs a full settle again.
        repeat (30) step();
        #1 rst_n = 1'b0;
        step();
        check_idle("midreset");
        #1 rst_n = 1'b1;
        wait_fs(60, n);
        check("midreset_latency", 32'(n), 20);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
